clock_set_ctrl: RTL and testbench

Time-set controller for the digital clock. Sits between the debounced push-buttons and the counter/`control_decode_7seg` datapath. It sequences the user through editing year, month, day, hour, minute and second. While a field is being edited, the block pauses the counters, blinks that field's display enable, and issues one-cycle increment pulses to the selected counter.

---
 rtl/clock_pkg.sv | 62 ++++++
 rtl/btn_pulse.sv | 65 ++++++
 rtl/clock_set_ctrl.sv | 148 ++++++++++++++
 tb/tb_clock_set_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock time-set logic: state encoding,
// field indices and small helpers used by the set controller.
package clock_pkg;

  localparam logic [2:0] ST_RUN    = 3'd0;
  localparam logic [2:0] ST_SET_Y  = 3'd1;
  localparam logic [2:0] ST_SET_MO = 3'd2;
  localparam logic [2:0] ST_SET_D  = 3'd3;
  localparam logic [2:0] ST_SET_H  = 3'd4;
  localparam logic [2:0] ST_SET_MI = 3'd5;
  localparam logic [2:0] ST_SET_S  = 3'd6;

  typedef enum logic [2:0] {
    RUN    = ST_RUN,
    SET_Y  = ST_SET_Y,
    SET_MO = ST_SET_MO,
    SET_D  = ST_SET_D,
    SET_H  = ST_SET_H,
    SET_MI = ST_SET_MI,
    SET_S  = ST_SET_S
  } state_t;

  // Bit positions inside inc_field and the enable vector {y,mo,d,h,mi,s}.
  localparam int F_S  = 0;
  localparam int F_MI = 1;
  localparam int F_H  = 2;
  localparam int F_D  = 3;
  localparam int F_MO = 4;
  localparam int F_Y  = 5;

  // Counter width able to hold 0..n-1, never below one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Order in which a mode press walks through the fields.
  function automatic state_t next_mode_state(input state_t s);
    case (s)
      RUN:     return SET_Y;
      SET_Y:   return SET_MO;
      SET_MO:  return SET_D;
      SET_D:   return SET_H;
      SET_H:   return SET_MI;
      SET_MI:  return SET_S;
      default: return RUN;
    endcase
  endfunction

  // One-hot field selected by a SET state; zero in RUN.
  function automatic logic [5:0] field_onehot(input state_t s);
    case (s)
      SET_Y:   return 6'b1 << F_Y;
      SET_MO:  return 6'b1 << F_MO;
      SET_D:   return 6'b1 << F_D;
      SET_H:   return 6'b1 << F_H;
      SET_MI:  return 6'b1 << F_MI;
      SET_S:   return 6'b1 << F_S;
      default: return 6'b0;
    endcase
  endfunction

endpackage

// File: rtl/btn_pulse.sv
// Rising-edge detector for one debounced button, with optional hold-to-repeat.
// pulse is combinational from registers and the current level; the caller
// registers it. While reset is high the level is captured so a button held
// through reset produces no edge afterwards.
module btn_pulse
  import clock_pkg::*;
#(
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter bit REPEAT_EN     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic btn_q;
  logic rise;
  logic rep_pulse;

  // Previous level for edge detection; also loaded during reset.
  always_ff @(posedge clk) begin
    btn_q <= btn;
  end

  assign rise  = btn & ~btn_q & ~rst;
  assign pulse = rise | rep_pulse;

  if (REPEAT_EN) begin : g_repeat
    localparam int CW = cnt_width((HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES) + 1);
    logic [CW-1:0] hold_cnt;
    logic          armed;
    logic          repeating;
    logic          held;
    logic          fire;

    // Only a hold that started with a real edge may repeat.
    assign held      = btn & btn_q;
    assign fire      = armed & held & (repeating ? (hold_cnt == CW'(REPEAT_CYCLES))
                                                 : (hold_cnt == CW'(HOLD_CYCLES)));
    assign rep_pulse = fire & ~rst;

    // Count cycles since the edge (or since the last repeat) while held.
    always_ff @(posedge clk) begin
      if (rst || !btn) begin
        hold_cnt  <= '0;
        armed     <= 1'b0;
        repeating <= 1'b0;
      end else if (rise) begin
        hold_cnt  <= CW'(1);
        armed     <= 1'b1;
        repeating <= 1'b0;
      end else if (fire) begin
        hold_cnt  <= CW'(1);
        repeating <= 1'b1;
      end else if (armed) begin
        hold_cnt  <= hold_cnt + CW'(1);
      end
    end
  end else begin : g_no_repeat
    assign rep_pulse = 1'b0;
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set controller: walks the user through year..second editing, pauses
// the counters, blinks the selected field and issues increment pulses.
// Optional feature: define CLOCK_SET_AUTO_REPEAT_EN for hold-to-repeat on btn_inc.
// Handshake note: there is no valid/ready here; inc_field bits are single-cycle
// strobes that the counters must consume in the cycle they are high.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int BLINK_HALF     = 25_000_000,
  parameter int TIMEOUT_CYCLES = 500_000_000,
  parameter int HOLD_CYCLES    = 25_000_000,
  parameter int REPEAT_CYCLES  = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       run,
  output logic       set_mode,
  output logic [5:0] inc_field,
  output logic       enable_s,
  output logic       enable_mi,
  output logic       enable_h,
  output logic       enable_d,
  output logic       enable_mo,
  output logic       enable_y,
  output logic [2:0] dbg_state
);

`ifdef CLOCK_SET_AUTO_REPEAT_EN
  localparam bit INC_REPEAT = 1'b1;
`else
  localparam bit INC_REPEAT = 1'b0;
`endif

  localparam int BW = cnt_width(BLINK_HALF);
  localparam int TW = cnt_width(TIMEOUT_CYCLES);

  logic          mode_p;
  logic          inc_p;
  state_t        state_q, state_n;
  logic [BW-1:0] blink_cnt_q, blink_cnt_n;
  logic          blink_phase_q, blink_phase_n;
  logic [TW-1:0] to_cnt_q, to_cnt_n;
  logic [5:0]    inc_n;
  logic [5:0]    en_n;
  logic          changed;

  btn_pulse #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES),
    .REPEAT_EN    (1'b0)
  ) u_mode_pulse (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_mode),
    .pulse(mode_p)
  );

  btn_pulse #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES),
    .REPEAT_EN    (INC_REPEAT)
  ) u_inc_pulse (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_inc),
    .pulse(inc_p)
  );

  assign dbg_state = state_q;

  // Next state, increment strobe, blink and timeout counters, enables.
  always_comb begin
    state_n       = state_q;
    inc_n         = 6'b0;
    blink_cnt_n   = blink_cnt_q;
    blink_phase_n = blink_phase_q;
    to_cnt_n      = to_cnt_q;
    en_n          = 6'h3f;
    changed       = 1'b0;

    // Mode beats inc; an inc in the timeout cycle keeps the user in SET.
    if (mode_p) begin
      state_n = next_mode_state(state_q);
    end else if (state_q != RUN && inc_p) begin
      inc_n = field_onehot(state_q);
    end else if (state_q != RUN && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_n = RUN;
    end
    changed = (state_n != state_q);

    // A newly selected field always starts in its visible half.
    if (changed) begin
      blink_cnt_n   = '0;
      blink_phase_n = 1'b1;
    end else if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
      blink_cnt_n   = '0;
      blink_phase_n = ~blink_phase_q;
    end else begin
      blink_cnt_n   = blink_cnt_q + BW'(1);
    end

    if (changed || mode_p || inc_p || state_n == RUN) begin
      to_cnt_n = '0;
    end else begin
      to_cnt_n = to_cnt_q + TW'(1);
    end

    if (state_n != RUN) begin
      en_n = ~field_onehot(state_n) | {6{blink_phase_n}};
    end
  end

  // State, counters and all outputs are registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      to_cnt_q      <= '0;
      run           <= 1'b1;
      set_mode      <= 1'b0;
      inc_field     <= 6'b0;
      enable_y      <= 1'b1;
      enable_mo     <= 1'b1;
      enable_d      <= 1'b1;
      enable_h      <= 1'b1;
      enable_mi     <= 1'b1;
      enable_s      <= 1'b1;
    end else begin
      state_q       <= state_n;
      blink_cnt_q   <= blink_cnt_n;
      blink_phase_q <= blink_phase_n;
      to_cnt_q      <= to_cnt_n;
      run           <= (state_n == RUN);
      set_mode      <= (state_n != RUN);
      inc_field     <= inc_n;
      enable_y      <= en_n[F_Y];
      enable_mo     <= en_n[F_MO];
      enable_d      <= en_n[F_D];
      enable_h      <= en_n[F_H];
      enable_mi     <= en_n[F_MI];
      enable_s      <= en_n[F_S];
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios plus a randomized run checked
// against a cycle-level model built from time-since-entry / time-since-clear.
module tb_clock_set_ctrl;

  localparam int BH = 4;
  localparam int TO = 64;
  localparam int HC = 8;
  localparam int RC = 3;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       run, set_mode;
  logic [5:0] inc_field;
  logic       enable_s, enable_mi, enable_h, enable_d, enable_mo, enable_y;
  logic [2:0] dbg_state;
  logic [5:0] en_obs;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int         m_state = 0;
  int         m_since_clear = 0;
  int         m_since_entry = 0;
  int         m_held = 0;
  bit         m_armed = 1'b0;
  bit         m_pm = 1'b0;
  bit         m_pi = 1'b0;
  logic [5:0] m_inc = 6'b0;

  clock_set_ctrl #(
    .BLINK_HALF    (BH),
    .TIMEOUT_CYCLES(TO),
    .HOLD_CYCLES   (HC),
    .REPEAT_CYCLES (RC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .run      (run),
    .set_mode (set_mode),
    .inc_field(inc_field),
    .enable_s (enable_s),
    .enable_mi(enable_mi),
    .enable_h (enable_h),
    .enable_d (enable_d),
    .enable_mo(enable_mo),
    .enable_y (enable_y),
    .dbg_state(dbg_state)
  );

  assign en_obs = {enable_y, enable_mo, enable_d, enable_h, enable_mi, enable_s};

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected enable vector from the model: selected field dark in odd half-periods.
  function automatic logic [5:0] exp_en();
    logic [5:0] e;
    e = 6'h3f;
    if (m_state != 0 && ((m_since_entry / BH) % 2) == 1) e[6 - m_state] = 1'b0;
    return e;
  endfunction

  // Drive one cycle of inputs and advance the model across the clock edge.
  task automatic cycle(input logic m, input logic i, input logic r);
    bit me, ie, rep, ev;
    int nxt;
    btn_mode = m;
    btn_inc  = i;
    rst      = r;
    @(posedge clk);
    #1;
    if (r) begin
      m_state = 0; m_since_clear = 0; m_since_entry = 0;
      m_held = 0; m_armed = 1'b0; m_inc = 6'b0;
    end else begin
      me = m && !m_pm;
      ie = i && !m_pi;
      if (!i) begin
        m_armed = 1'b0; m_held = 0;
      end else if (ie) begin
        m_armed = 1'b1; m_held = 0;
      end else if (m_armed) begin
        m_held++;
      end
      rep = AR && i && !ie && m_armed && m_held >= HC && ((m_held - HC) % RC) == 0;
      ev  = ie || rep;
      nxt = m_state;
      if (me) nxt = (m_state + 1) % 7;
      else if (m_state != 0 && !ev && m_since_clear == TO - 1) nxt = 0;
      m_inc = (m_state != 0 && !me && ev) ? (6'b1 << (6 - m_state)) : 6'b0;
      m_since_clear = (nxt != m_state || me || ev || nxt == 0) ? 0 : m_since_clear + 1;
      m_since_entry = (nxt != m_state) ? 0 : m_since_entry + 1;
      m_state = nxt;
    end
    m_pm = m;
    m_pi = i;
  endtask

  // Step mode presses until the DUT sits in the target state (bounded).
  task automatic goto(input int target);
    for (int k = 0; k < 8; k++) begin
      if (int'(dbg_state) == target) break;
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    checks++;
    if (run !== 1'b1 || set_mode !== 1'b0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got run=%b set=%b st=%0d expected run=1 set=0 st=0", run, set_mode, dbg_state);
    end
    checks++;
    if (en_obs !== 6'h3f || inc_field !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%h inc=%h expected en=3f inc=00", en_obs, inc_field);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b1, 1'b0);
      checks++;
      if (dbg_state !== 3'd0 || inc_field !== 6'b0 || run !== 1'b1) begin
        errors++;
        $display("FAIL reset_no_edge: got st=%0d inc=%h run=%b expected st=0 inc=00 run=1", dbg_state, inc_field, run);
      end
    end
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_mode_walk();
    for (int i = 1; i <= 7; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if (dbg_state !== 3'(i % 7) || run !== (i == 7) || set_mode !== (i != 7)) begin
        errors++;
        $display("FAIL mode_walk_%0d: got st=%0d run=%b set=%b expected st=%0d run=%b", i, dbg_state, run, set_mode, i % 7, i == 7);
      end
      cycle(1'b0, 1'b0, 1'b0);
      checks++;
      if (dbg_state !== 3'(i % 7)) begin
        errors++;
        $display("FAIL mode_hold_%0d: got st=%0d expected %0d", i, dbg_state, i % 7);
      end
    end
  endtask

  task automatic test_set_h_inc();
    logic [11:0] pat;
    logic        pressed;
    pat = 12'b1111_0000_1111;
    goto(3);
    cycle(1'b1, 1'b0, 1'b0);
    checks++;
    if (dbg_state !== 3'd4 || en_obs !== 6'h3f) begin
      errors++;
      $display("FAIL set_h_entry: got st=%0d en=%h expected st=4 en=3f", dbg_state, en_obs);
    end
    for (int t = 1; t < 12; t++) begin
      pressed = (t == 1 || t == 5 || t == 9);
      cycle(1'b0, pressed, 1'b0);
      checks++;
      if (enable_h !== pat[t] || {enable_y, enable_mo, enable_d, enable_mi, enable_s} !== 5'h1f) begin
        errors++;
        $display("FAIL set_h_blink_t%0d: got en=%h expected enable_h=%b others 1", t, en_obs, pat[t]);
      end
      checks++;
      if (inc_field !== (pressed ? 6'b000100 : 6'b0)) begin
        errors++;
        $display("FAIL set_h_inc_t%0d: got %b expected %b", t, inc_field, pressed ? 6'b000100 : 6'b0);
      end
    end
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_simultaneous();
    goto(3);
    cycle(1'b1, 1'b1, 1'b0);
    checks++;
    if (dbg_state !== 3'd4 || inc_field !== 6'b0) begin
      errors++;
      $display("FAIL simultaneous: got st=%0d inc=%b expected st=4 inc=000000", dbg_state, inc_field);
    end
    cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (inc_field !== 6'b0) begin
      errors++;
      $display("FAIL simultaneous_after: got inc=%b expected 000000", inc_field);
    end
  endtask

  task automatic test_timeout();
    goto(1);
    cycle(1'b1, 1'b0, 1'b0);
    for (int t = 1; t <= 64; t++) begin
      cycle(1'b0, 1'b0, 1'b0);
      checks++;
      if (dbg_state !== ((t < 64) ? 3'd2 : 3'd0)) begin
        errors++;
        $display("FAIL timeout_idle_t%0d: got st=%0d expected %0d", t, dbg_state, (t < 64) ? 2 : 0);
      end
    end
    goto(1);
    cycle(1'b1, 1'b0, 1'b0);
    for (int t = 1; t <= 124; t++) begin
      cycle(1'b0, t == 60, 1'b0);
      checks++;
      if (dbg_state !== ((t < 124) ? 3'd2 : 3'd0)) begin
        errors++;
        $display("FAIL timeout_inc_t%0d: got st=%0d expected %0d", t, dbg_state, (t < 124) ? 2 : 0);
      end
      if (t == 60) begin
        checks++;
        if (inc_field !== 6'b010000) begin
          errors++;
          $display("FAIL timeout_inc_pulse: got %b expected 010000", inc_field);
        end
      end
    end
  endtask

  task automatic test_auto_repeat();
    logic exp;
    goto(5);
    cycle(1'b1, 1'b0, 1'b0);
    for (int t = 1; t <= 24; t++) begin
      cycle(1'b0, t <= 20, 1'b0);
      exp = (t == 1) || (AR && (t == 9 || t == 12 || t == 15 || t == 18));
      checks++;
      if (inc_field !== (exp ? 6'b000001 : 6'b0)) begin
        errors++;
        $display("FAIL auto_repeat_t%0d: got %b expected %b", t, inc_field, exp ? 6'b000001 : 6'b0);
      end
    end
  endtask

  task automatic test_random();
    logic m, i, r;
    int   pm, pi;
    m = 1'b0;
    i = 1'b0;
    cycle(1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 1500; n++) begin
      if (n % 150 == 0) begin
        if ($urandom_range(0, 2) == 0) begin pm = 300; pi = 150; end
        else begin pm = 12; pi = 4; end
      end
      if ($urandom_range(0, pm - 1) == 0) m = ~m;
      if ($urandom_range(0, pi - 1) == 0) i = ~i;
      r = ($urandom_range(0, 399) == 0);
      cycle(m, i, r);
      checks++;
      if (int'(dbg_state) != m_state || run !== (m_state == 0) || set_mode !== (m_state != 0)) begin
        errors++;
        $display("FAIL random_state_n%0d: got st=%0d run=%b set=%b expected st=%0d", n, dbg_state, run, set_mode, m_state);
      end
      checks++;
      if (inc_field !== m_inc) begin
        errors++;
        $display("FAIL random_inc_n%0d: got %b expected %b", n, inc_field, m_inc);
      end
      checks++;
      if (en_obs !== exp_en()) begin
        errors++;
        $display("FAIL random_en_n%0d: got %b expected %b", n, en_obs, exp_en());
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode_walk();
    test_set_h_inc();
    test_simultaneous();
    test_timeout();
    test_auto_repeat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
